// File: rtl/md_pkg.sv
// Shared encodings and op-decoding helpers for the multiply/divide unit.
package md_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  // Divide family (DIV/DIVU/REM/REMU)
  function automatic logic IsDiv(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 treated as signed
  function automatic logic IsSignedA(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 treated as signed
  function automatic logic IsSignedB(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate, used for magnitudes and final sign fix.
module md_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] value_i,
  input  logic         neg_i,
  output logic [W-1:0] value_c
);

  // Negate when requested, pass through otherwise
  assign value_c = neg_i ? (~value_i + W'(1)) : value_i;

endmodule

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            Start_i,
  input  logic [2:0]      MdCtrl_i,
  input  logic [XLEN-1:0] OperandA_i,
  input  logic [XLEN-1:0] OperandB_i,
  input  logic            Flush_i,
  output logic            Busy_o,
  output logic            Done_o,
  output logic [XLEN-1:0] Result_o
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam int unsigned W2 = 2 * XLEN;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      op_q, op_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic            busy_q, busy_d, done_q, done_d;

  logic            sa_c, sb_c, b_zero_c, ovf_c, div_neg_c;
  logic [XLEN-1:0] mag_a_c, mag_b_c, div_word_c, div_fix_c, fix_result_c;
  logic [XLEN:0]   mul_sum_c, div_shift_c, div_trial_c;
  logic [W2-1:0]   mul_next_c, div_next_c, prod_fix_c;

  // Operand signs and special-case detection on the request inputs
  assign sa_c     = IsSignedA(MdCtrl_i) & OperandA_i[XLEN-1];
  assign sb_c     = IsSignedB(MdCtrl_i) & OperandB_i[XLEN-1];
  assign b_zero_c = (OperandB_i == '0);
  assign ovf_c    = ((MdCtrl_i == MD_DIV) || (MdCtrl_i == MD_REM)) &&
                    (OperandA_i == XMIN) && (OperandB_i == {XLEN{1'b1}});

  md_sign_fix #(.W(XLEN)) u_mag_a (.value_i(OperandA_i), .neg_i(sa_c), .value_c(mag_a_c));
  md_sign_fix #(.W(XLEN)) u_mag_b (.value_i(OperandB_i), .neg_i(sb_c), .value_c(mag_b_c));

  // Multiply step: conditional add into upper half, carry kept, shift right
  assign mul_sum_c  = {1'b0, acc_q[W2-1:XLEN]} + {1'b0, b_q};
  assign mul_next_c = acc_q[0] ? {mul_sum_c, acc_q[XLEN-1:1]} : {1'b0, acc_q[W2-1:1]};

  // Divide step: acc = {remainder, dividend/quotient}, shift left and trial-subtract
  assign div_shift_c = acc_q[W2-1:XLEN-1];
  assign div_trial_c = div_shift_c - {1'b0, b_q};
  assign div_next_c  = div_trial_c[XLEN] ? {div_shift_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                         : {div_trial_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  // Final sign correction: full-width product, or the selected quotient/remainder word
  assign div_word_c = op_q[1] ? acc_q[W2-1:XLEN] : acc_q[XLEN-1:0];
  assign div_neg_c  = op_q[1] ? sign_a_q : (sign_a_q ^ sign_b_q);

  md_sign_fix #(.W(W2))   u_fix_prod (.value_i(acc_q), .neg_i(sign_a_q ^ sign_b_q), .value_c(prod_fix_c));
  md_sign_fix #(.W(XLEN)) u_fix_div  (.value_i(div_word_c), .neg_i(div_neg_c), .value_c(div_fix_c));

  assign fix_result_c = IsDiv(op_q)         ? div_fix_c :
                        (op_q == MD_MUL)    ? prod_fix_c[XLEN-1:0] :
                                              prod_fix_c[W2-1:XLEN];

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    acc_d    = acc_q;
    b_d      = b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    result_d = result_q;

    if (Flush_i) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Start_i) begin
            op_d     = MdCtrl_i;
            sign_a_d = sa_c;
            sign_b_d = sb_c;
            count_d  = '0;
            b_d      = mag_b_c;
            acc_d    = {{XLEN{1'b0}}, mag_a_c};
            if (IsDiv(MdCtrl_i) && b_zero_c) begin
              result_d = MdCtrl_i[1] ? OperandA_i : {XLEN{1'b1}};
              state_d  = DONE;
            end else if (ovf_c) begin
              result_d = MdCtrl_i[1] ? {XLEN{1'b0}} : XMIN;
              state_d  = DONE;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          acc_d   = IsDiv(op_q) ? div_next_c : mul_next_c;
          count_d = count_q + CW'(1);
          if (count_q == CW'(XLEN - 1)) begin
            count_d = '0;
            state_d = FIX;
          end
        end
        FIX: begin
          result_d = fix_result_c;
          state_d  = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Busy_o   = busy_q;
  assign Done_o   = done_q;
  assign Result_o = result_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit against a plain-arithmetic RV32M model.
module tb_md_unit;
  import md_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        Start_i;
  logic [2:0]  MdCtrl_i;
  logic [31:0] OperandA_i, OperandB_i;
  logic        Flush_i;
  logic        Busy_o, Done_o;
  logic [31:0] Result_o;

  md_unit #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .Start_i(Start_i), .MdCtrl_i(MdCtrl_i),
    .OperandA_i(OperandA_i), .OperandB_i(OperandB_i), .Flush_i(Flush_i),
    .Busy_o(Busy_o), .Done_o(Done_o), .Result_o(Result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] due;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RV32M reference using 64-bit integer arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      MD_MUL:    begin p = 64'(ua * ub); return p[31:0];  end
      MD_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      MD_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      MD_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      MD_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REM:    begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = 64'(sa % sb); return p[31:0];
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 1'b0;
    if (b == 0) return 1'b1;
    return ((op == MD_DIV) || (op == MD_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  // Monitor: pop and compare on every completion, otherwise result must hold
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (!rst_ni) begin
      last_res = '0;
    end else if (Done_o) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'(Done_o), 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("result", 64'(Result_o), 64'(e.res));
        chk("done_cycle", 64'(cyc), 64'(e.due));
      end
      last_res = Result_o;
    end else begin
      chk("result_hold", 64'(Result_o), 64'(last_res));
    end
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 80 && Busy_o; k++) tick();
    chk("idle_before_start", 64'(Busy_o), 64'd0);
  endtask

  // Drive a request in the current (IDLE) cycle; returns that cycle's index
  task automatic start_raw(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int c0);
    Start_i    = 1'b1;
    MdCtrl_i   = op;
    OperandA_i = a;
    OperandB_i = b;
    c0         = cyc;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   c0;
    wait_idle();
    e.res = ref_md(op, a, b);
    e.due = 32'(cyc + (is_special(op, a, b) ? 1 : 34));
    sb_q.push_back(e);
    start_raw(op, a, b, c0);
    tick();
    chk("busy_accept", 64'(Busy_o), 64'd1);
    Start_i = 1'b0;
    for (int k = 0; k < 60 && sb_q.size() != 0; k++) begin
      Start_i    = 1'($urandom_range(0, 1));
      MdCtrl_i   = 3'($urandom);
      OperandA_i = $urandom;
      OperandB_i = $urandom;
      tick();
    end
    Start_i = 1'b0;
    if (sb_q.size() != 0) begin
      chk("done_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
    tick();
    chk("busy_after_done", 64'(Busy_o), 64'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int          c0;
    int          sel;
    logic [2:0]  op;
    logic [31:0] a, b;

    rst_ni = 1'b0; Start_i = 1'b0; Flush_i = 1'b0;
    MdCtrl_i = '0; OperandA_i = '0; OperandB_i = '0;
    #3;
    chk("rst_busy", 64'(Busy_o), 64'd0);
    chk("rst_done", 64'(Done_o), 64'd0);
    chk("rst_result", 64'(Result_o), 64'd0);
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();

    // Directed cases
    do_op(MD_MUL,    32'd7, 32'hFFFF_FFFD);
    do_op(MD_MULH,   32'd7, 32'hFFFF_FFFD);
    do_op(MD_MULHU,  32'd7, 32'hFFFF_FFFD);
    do_op(MD_DIV,    32'hFFFF_FFEC, 32'd3);
    do_op(MD_REM,    32'hFFFF_FFEC, 32'd3);
    do_op(MD_REMU,   32'd20, 32'd3);
    do_op(MD_DIVU,   32'h1234_5678, 32'd0);
    do_op(MD_REM,    32'h1234_5678, 32'd0);
    do_op(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF);
    do_op(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF);

    // Flush in cycle 10 of a MULHSU: no completion, busy drops next cycle
    wait_idle();
    start_raw(MD_MULHSU, 32'h0BAD_F00D, 32'h1357_9BDF, c0);
    tick();
    Start_i = 1'b0;
    for (int k = 0; k < 20 && cyc != c0 + 10; k++) tick();
    Flush_i = 1'b1;
    tick();
    Flush_i = 1'b0;
    chk("flush_busy_low", 64'(Busy_o), 64'd0);
    repeat (40) tick();
    do_op(MD_MULHSU, 32'hFFFF_FFFF, 32'd2);

    // Flush together with start in IDLE: request is dropped
    Flush_i = 1'b1;
    start_raw(MD_MUL, 32'd5, 32'd6, c0);
    tick();
    Flush_i = 1'b0;
    Start_i = 1'b0;
    chk("flush_start_idle", 64'(Busy_o), 64'd0);
    repeat (40) tick();

    // Asynchronous reset mid-CALC clears outputs at once, no completion
    do_op(MD_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    start_raw(MD_MUL, 32'h0000_1234, 32'h0000_5678, c0);
    tick();
    Start_i = 1'b0;
    repeat (5) tick();
    rst_ni = 1'b0;
    #1;
    chk("async_rst_busy", 64'(Busy_o), 64'd0);
    chk("async_rst_done", 64'(Done_o), 64'd0);
    chk("async_rst_result", 64'(Result_o), 64'd0);
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (40) tick();

    // Randomized operations with boundary operands mixed in
    for (int i = 0; i < 60; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(0, 10)) - 32'd5; end
      else if (sel == 3) b = 32'h8000_0000;
      do_op(op, a, b);
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
